// File: rtl/mux_scan_collector.sv
// Drives a 4:1 mux select through 0..3, lets each select settle, samples y into a
// 4-bit word and offers the finished word on a valid/ack handshake.
module mux_scan_collector #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       y_i,
  input  logic       ack_i,
  output logic       s1_o,
  output logic       s0_o,
  output logic       busy_o,
  output logic [3:0] word_o,
  output logic       valid_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] word_q, word_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    word_d  = word_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETTLE;
          sel_d   = 2'd0;
          word_d  = 4'd0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        // Select is held through the sample cycle; it only moves on exit.
        word_d[sel_q] = y_i;
        if (sel_q == 2'd3) begin
          state_d = DONE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = SETTLE;
          sel_d   = sel_q + 2'd1;
          cnt_d   = CNT_INIT;
        end
      end
      DONE: begin
        if (ack_i) begin
          valid_d = 1'b0;
          if (start_i) begin
            state_d = SETTLE;
            sel_d   = 2'd0;
            word_d  = 4'd0;
            cnt_d   = CNT_INIT;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s1_o    = sel_q[1];
  assign s0_o    = sel_q[0];
  assign busy_o  = busy_q;
  assign word_o  = word_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_mux_scan_collector.sv
// Bench for mux_scan_collector: two instances (settle 1 and 3), each feeding a
// behavioural 4:1 mux, checked per cycle against the expected select timeline.
module tb_mux_scan_collector;

  logic       clk = 1'b0;
  logic       reset, start, ack;
  logic [3:0] da, db;
  logic       s1a, s0a, busya, valida, ya;
  logic       s1b, s0b, busyb, validb, yb;
  logic [3:0] worda, wordb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign ya = da[{s1a, s0a}];
  assign yb = db[{s1b, s0b}];

  mux_scan_collector #(.SETTLE_CYCLES(1)) dut_a (
    .clk_i(clk), .reset_i(reset), .start_i(start), .y_i(ya), .ack_i(ack),
    .s1_o(s1a), .s0_o(s0a), .busy_o(busya), .word_o(worda), .valid_o(valida));

  mux_scan_collector #(.SETTLE_CYCLES(3)) dut_b (
    .clk_i(clk), .reset_i(reset), .start_i(start), .y_i(yb), .ack_i(ack),
    .s1_o(s1b), .s0_o(s0b), .busy_o(busyb), .word_o(wordb), .valid_o(validb));

  typedef struct {
    logic [3:0] d;
    logic [3:0] exp_word;
    bit         spam;
    int         hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rd(input int inst, output logic [1:0] sel, output logic busy,
                    output logic valid, output logic [3:0] word);
    if (inst == 0) begin sel = {s1a, s0a}; busy = busya; valid = valida; word = worda; end
    else           begin sel = {s1b, s0b}; busy = busyb; valid = validb; word = wordb; end
  endtask

  // One full scan; expected select at k cycles after the start edge is k/(S+1).
  task automatic scan(input int inst, input logic [3:0] dv, input logic [3:0] expw,
                      input bit spam, input bit with_ack);
    int s = (inst == 0) ? 1 : 3;
    int l = 4 * (s + 1);
    logic [1:0] sel; logic busy, valid; logic [3:0] word;
    if (inst == 0) da = dv; else db = dv;
    start = 1'b1; ack = with_ack;
    @(posedge clk); #1 start = 1'b0; ack = 1'b0;
    for (int k = 0; k < l; k++) begin
      @(negedge clk);
      rd(inst, sel, busy, valid, word);
      chk("scan_sel", 32'(sel), 32'(k / (s + 1)));
      chk("scan_busy", 32'(busy), 32'd1);
      chk("scan_valid", 32'(valid), 32'd0);
      if (spam && k == 2) begin start = 1'b1; ack = 1'b1; end
      @(posedge clk); #1 start = 1'b0; ack = 1'b0;
    end
    @(negedge clk);
    rd(inst, sel, busy, valid, word);
    chk("done_valid", 32'(valid), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_sel", 32'(sel), 32'd3);
    chk("done_word", 32'(word), 32'(expw));
  endtask

  task automatic hold(input int inst, input int n, input logic [3:0] expw);
    logic [1:0] sel; logic busy, valid; logic [3:0] word;
    for (int i = 0; i < n; i++) begin
      start = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      rd(inst, sel, busy, valid, word);
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_word", 32'(word), 32'(expw));
    end
  endtask

  task automatic release_ack(input int inst);
    logic [1:0] sel; logic busy, valid; logic [3:0] word;
    ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    rd(inst, sel, busy, valid, word);
    chk("ack_valid", 32'(valid), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
    chk("ack_sel_hold", 32'(sel), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[4];
    logic [3:0] dv;
    bit chain;
    tbl[0] = '{d: 4'b1010, exp_word: 4'b1010, spam: 1'b0, hold: 0};
    tbl[1] = '{d: 4'b1x01, exp_word: 4'b1x01, spam: 1'b0, hold: 5};
    tbl[2] = '{d: 4'b0011, exp_word: 4'b0011, spam: 1'b1, hold: 1};
    tbl[3] = '{d: 4'b1111, exp_word: 4'b1111, spam: 1'b0, hold: 2};

    reset = 1'b1; start = 1'b0; ack = 1'b0; da = 4'd0; db = 4'd0;
    #3;
    chk("rst_word", 32'(worda), 32'd0);
    chk("rst_valid", 32'(valida), 32'd0);
    chk("rst_busy", 32'(busya), 32'd0);
    chk("rst_sel", 32'({s1a, s0a}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed table: plain scan, x data with held valid, start/ack spam mid-scan.
    foreach (tbl[i]) begin
      scan(0, tbl[i].d, tbl[i].exp_word, tbl[i].spam, 1'b0);
      hold(0, tbl[i].hold, tbl[i].exp_word);
      release_ack(0);
    end

    // Back-to-back: ack and start together in DONE restart immediately.
    scan(0, 4'b1001, 4'b1001, 1'b0, 1'b0);
    scan(0, 4'b0110, 4'b0110, 1'b0, 1'b1);
    release_ack(0);

    // Asynchronous reset between edges mid-scan.
    da = 4'b1111; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_word", 32'(worda), 32'h3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_word", 32'(worda), 32'd0);
    chk("async_rst_valid", 32'(valida), 32'd0);
    chk("async_rst_busy", 32'(busya), 32'd0);
    chk("async_rst_sel", 32'({s1a, s0a}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    scan(0, 4'b0101, 4'b0101, 1'b0, 1'b0);
    release_ack(0);

    // Randomised scans against the select-timeline model.
    chain = 1'b0;
    for (int it = 0; it < 20; it++) begin
      dv = 4'($urandom);
      scan(0, dv, dv, bit'($urandom_range(0, 1)), chain);
      hold(0, $urandom_range(0, 3), dv);
      chain = bit'($urandom_range(0, 1));
      if (!chain) release_ack(0);
    end
    if (chain) release_ack(0);

    // Longer settle: each select held 4 cycles, valid after 16.
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    scan(1, 4'b1100, 4'b1100, 1'b0, 1'b0);
    hold(1, 2, 4'b1100);
    release_ack(1);
    scan(1, 4'b0110, 4'b0110, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
